// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and M-extension types for the execute stage.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// one bit per cycle on magnitudes with a sign fixup folded into the final result load.
module ex_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mdValidE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] srcAE,
  input  logic [XLEN-1:0] srcBE,
  input  logic            killE,
  output logic            stallMD,
  output logic            mdDoneE,
  output logic [XLEN-1:0] resultMD
);

  localparam int CW = $clog2(XLEN) + 1;

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;      // MUL: {partial product, multiplier}; DIV: low half is quotient
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   opb_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  md_op_e            op_q;

  md_op_e            op_e;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, div_ovf, early_out;
  logic [XLEN-1:0]   early_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, prod_fix;
  logic [XLEN:0]     div_shift, div_diff, rem_next;
  logic              div_ge;
  logic [XLEN-1:0]   quo_next, quo_fix, rem_fix;
  logic [XLEN-1:0]   mul_res, div_res;
  logic              last_iter;

  // Operand decode at issue.
  always_comb begin
    op_e      = md_op_e'(funct3E);
    a_signed  = (op_e == MD_MULH) || (op_e == MD_MULHSU) || (op_e == MD_DIV) || (op_e == MD_REM);
    b_signed  = (op_e == MD_MULH) || (op_e == MD_DIV) || (op_e == MD_REM);
    a_neg     = a_signed & srcAE[XLEN-1];
    b_neg     = b_signed & srcBE[XLEN-1];
    abs_a     = a_neg ? -srcAE : srcAE;
    abs_b     = b_neg ? -srcBE : srcBE;
    div_zero  = (srcBE == '0);
    div_ovf   = b_signed && (srcAE == {1'b1, {(XLEN-1){1'b0}}}) && (srcBE == '1);
    early_out = funct3E[2] & (div_zero | div_ovf);
    // Divide-by-zero and signed overflow bypass the iteration entirely.
    if (div_zero) early_res = funct3E[1] ? srcAE : '1;
    else          early_res = funct3E[1] ? '0    : srcAE;
  end

  // One iteration of multiply or divide, plus the result as it would be after fixup.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {rem_q, acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = ~div_diff[XLEN];
    rem_next  = div_ge ? div_diff : div_shift;
    quo_next  = {acc_q[XLEN-2:0], div_ge};
    prod_fix  = neg_res_q ? -mul_next : mul_next;
    mul_res   = (op_q == MD_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    quo_fix   = neg_res_q ? -quo_next : quo_next;
    rem_fix   = neg_rem_q ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
    div_res   = op_q[1] ? rem_fix : quo_fix;
    last_iter = (cnt_q == CW'(1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (killE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (mdValidE) state_d = early_out ? DONE : (funct3E[2] ? DIV : MUL);
        MUL:  if (last_iter) state_d = DONE;
        DIV:  if (last_iter) state_d = DONE;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stallMD = ((state_q == IDLE) & mdValidE & ~killE) | (state_q == MUL) | (state_q == DIV);
    mdDoneE = (state_q == DONE);
  end

  // A kill freezes the datapath so resultMD keeps the last completed value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opb_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      op_q      <= MD_MUL;
      resultMD  <= '0;
    end else if (!killE) begin
      case (state_q)
        IDLE: if (mdValidE) begin
          acc_q     <= {{XLEN{1'b0}}, abs_a};
          rem_q     <= '0;
          opb_q     <= abs_b;
          neg_res_q <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
          op_q      <= op_e;
          cnt_q     <= CW'(XLEN);
          if (early_out) resultMD <= early_res;
        end
        MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q - CW'(1);
          if (last_iter) resultMD <= mul_res;
        end
        DIV: begin
          acc_q[XLEN-1:0] <= quo_next;
          rem_q           <= rem_next[XLEN-1:0];
          cnt_q           <= cnt_q - CW'(1);
          if (last_iter) resultMD <= div_res;
        end
        default: ;
      endcase
    end
  end

endmodule
